// File: rtl/xor_reduce_pkg.sv
// Sizing helpers for the pipelined XOR reduction tree.
package xor_reduce_pkg;

  localparam int MAX_WIDTH = 256;

  function automatic int clog4(input int n);
    int r;
    int span;
    r = 0;
    span = 1;
    while (span < n) begin
      span = span * 4;
      r++;
    end
    return r;
  endfunction

  // ceil(w / 4^k): number of bits left after k reduction levels
  function automatic int level_width(input int w, input int k);
    int div;
    div = 1;
    for (int i = 0; i < k; i++) div = div * 4;
    return (w + div - 1) / div;
  endfunction

  function automatic int level_offset(input int w, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off = off + level_width(w, j);
    return off;
  endfunction

endpackage

// File: rtl/xor_reduce_level.sv
// One registered 4:1 XOR level plus its valid/frame tags; latency 1 enabled edge.
// No backpressure: advances on every edge with SP=1, holds with SP=0.
module xor_reduce_level
  import xor_reduce_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = level_width(IN_W, 1)
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic [IN_W-1:0]  d,
  input  logic             d_vld,
  input  logic             d_fs,
  input  logic             d_fe,
  output logic [OUT_W-1:0] q,
  output logic             q_vld,
  output logic             q_fs,
  output logic             q_fe
);

  logic [OUT_W-1:0] grp;

  // the top group is narrower when IN_W is not a multiple of 4
  for (genvar g = 0; g < OUT_W; g++) begin : g_grp
    localparam int LO = 4 * g;
    localparam int HI = (4 * g + 3 < IN_W) ? 4 * g + 3 : IN_W - 1;
    assign grp[g] = ^d[HI:LO];
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      q     <= '0;
      q_vld <= 1'b0;
      q_fs  <= 1'b0;
      q_fe  <= 1'b0;
    end else if (SP) begin
      q     <= grp;
      q_vld <= d_vld;
      q_fs  <= d_fs;
      q_fe  <= d_fe;
    end
  end

endmodule

// File: rtl/xor_reduce_pipe.sv
// Pipelined WIDTH-bit parity; latency LEVELS enabled edges (+1 with XOR_REDUCE_FRAME_EN,
// which adds frame accumulation and abort flag). No backpressure; SP=0 freezes all state.
module xor_reduce_pipe
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH = 21
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic             DV,
  input  logic [WIDTH-1:0] D,
  input  logic             FS,
  input  logic             FE,
  output logic             Z,
  output logic             ZV,
  output logic             ZF
);

  localparam int LEVELS = (clog4(WIDTH) > 1) ? clog4(WIDTH) : 1;
  localparam int TOTAL  = level_offset(WIDTH, LEVELS) + 1;

  // every level's bits packed end to end; level 0 is the raw input word
  logic [TOTAL-1:0] chain;
  logic [LEVELS:0]  vld_c;
  logic [LEVELS:0]  fs_c;
  logic [LEVELS:0]  fe_c;
  logic             p;

  assign chain[WIDTH-1:0] = D;
  assign vld_c[0]         = DV;
  assign fs_c[0]          = FS & DV;
  assign fe_c[0]          = FE & DV;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IW = level_width(WIDTH, k - 1);
    localparam int OW = level_width(WIDTH, k);
    localparam int IO = level_offset(WIDTH, k - 1);
    localparam int OO = level_offset(WIDTH, k);

    xor_reduce_level #(.IN_W(IW)) u_lvl (
      .CK    (CK),
      .CD    (CD),
      .SP    (SP),
      .d     (chain[IO +: IW]),
      .d_vld (vld_c[k-1]),
      .d_fs  (fs_c[k-1]),
      .d_fe  (fe_c[k-1]),
      .q     (chain[OO +: OW]),
      .q_vld (vld_c[k]),
      .q_fs  (fs_c[k]),
      .q_fe  (fe_c[k])
    );
  end

  assign p = chain[TOTAL-1];

`ifdef XOR_REDUCE_FRAME_EN
  logic in_frame;
  logic acc;
  logic par;

  // a frame start discards whatever partial parity was accumulated
  always_comb begin
    par = (fs_c[LEVELS] ? 1'b0 : acc) ^ p;
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      in_frame <= 1'b0;
      acc      <= 1'b0;
      Z        <= 1'b0;
      ZV       <= 1'b0;
      ZF       <= 1'b0;
    end else if (SP) begin
      ZV <= 1'b0;
      ZF <= 1'b0;
      if (vld_c[LEVELS]) begin
        ZF <= fs_c[LEVELS] & in_frame;
        if (fe_c[LEVELS]) begin
          Z        <= par;
          ZV       <= 1'b1;
          acc      <= 1'b0;
          in_frame <= 1'b0;
        end else begin
          acc      <= par;
          in_frame <= 1'b1;
        end
      end
    end
  end
`else
  assign Z  = p;
  assign ZV = vld_c[LEVELS];
  assign ZF = 1'b0;

  logic unused_tags;
  assign unused_tags = &{1'b0, fs_c, fe_c};
`endif

endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Directed scoreboard bench for xor_reduce_pipe (WIDTH=21 and WIDTH=1 instances).
`timescale 1ns/1ps
module tb_xor_reduce_pipe;

  localparam int W = 21;
`ifdef XOR_REDUCE_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif
  localparam int LAT  = 3 + (FRAME ? 1 : 0);
  localparam int LAT1 = 1 + (FRAME ? 1 : 0);

  typedef struct {
    logic z;
    logic zv;
    logic zf;
    int   due;
  } exp_t;

  logic         CK, CD, SP;
  logic         DV, FS, FE, Z, ZV, ZF;
  logic [W-1:0] D;
  logic         DV1, FS1, FE1, Z1, ZV1, ZF1;
  logic [0:0]   D1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   en_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  xor_reduce_pipe #(.WIDTH(W)) dut (
    .CK(CK), .CD(CD), .SP(SP), .DV(DV), .D(D), .FS(FS), .FE(FE),
    .Z(Z), .ZV(ZV), .ZF(ZF)
  );

  xor_reduce_pipe #(.WIDTH(1)) dut1 (
    .CK(CK), .CD(CD), .SP(SP), .DV(DV1), .D(D1), .FS(FS1), .FE(FE1),
    .Z(Z1), .ZV(ZV1), .ZF(ZF1)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  always @(posedge CK) if (SP && !CD) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic exp0(input logic z, input logic zv, input logic zf);
    exp_t e;
    e.z = z; e.zv = zv; e.zf = zf; e.due = en_cnt + LAT;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic z);
    exp_t e;
    e.z = z; e.zv = 1'b1; e.zf = 1'b0; e.due = en_cnt + LAT1;
    q1.push_back(e);
  endtask

  task automatic fword(input logic [W-1:0] d, input logic fs, input logic fe);
    DV = 1'b1; D = d; FS = fs; FE = fe;
    @(posedge CK); #1;
    DV = 1'b0; FS = 1'b0; FE = 1'b0; D = '0;
  endtask

  // standalone word: in frame builds it is a single-word frame
  task automatic word(input logic [W-1:0] d, input logic z);
    exp0(z, 1'b1, 1'b0);
    fword(d, FRAME, FRAME);
  endtask

  task automatic word1(input logic b);
    exp1(b);
    DV1 = 1'b1; D1 = b; FS1 = FRAME; FE1 = FRAME;
    @(posedge CK); #1;
    DV1 = 1'b0; D1 = 1'b0; FS1 = 1'b0; FE1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  always @(negedge CK) begin
    if (!CD && SP && (ZV || ZF)) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL out0_unexpected: ZV=%0d ZF=%0d Z=%0d, expected no output", ZV, ZF, Z);
      end else begin
        e0 = q0.pop_front();
        if (e0.zv) chk("out0_z", Z, e0.z);
        chk("out0_zv", ZV, e0.zv);
        chk("out0_zf", ZF, e0.zf);
        chk("out0_latency", en_cnt, e0.due);
      end
    end
  end

  always @(negedge CK) begin
    if (!CD && SP && (ZV1 || ZF1)) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL out1_unexpected: ZV=%0d ZF=%0d Z=%0d, expected no output", ZV1, ZF1, Z1);
      end else begin
        e1 = q1.pop_front();
        chk("out1_z", Z1, e1.z);
        chk("out1_zf", ZF1, e1.zf);
        chk("out1_latency", en_cnt, e1.due);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    bit seen;
    CD = 1'b1; SP = 1'b1; DV = 1'b0; D = '0; FS = 1'b0; FE = 1'b0;
    DV1 = 1'b0; D1 = 1'b0; FS1 = 1'b0; FE1 = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("reset_z", Z, 0);
    chk("reset_zv", ZV, 0);
    chk("reset_zf", ZF, 0);
    chk("reset_z1", Z1, 0);
    chk("reset_zv1", ZV1, 0);
    @(negedge CK);
    CD = 1'b0;
    @(posedge CK); #1;

    // basic odd / even words
    word(21'h000001, 1'b1);
    word(21'h000003, 1'b0);
    idle(6);

    // walking one, then all ones (21 ones: odd)
    for (int i = 0; i < W; i++) begin
      v = '0;
      v[i] = 1'b1;
      word(v, 1'b1);
    end
    word(21'h1FFFFF, 1'b1);
    idle(6);

    // two-cycle stall while results sit at the output
    word(21'h0ABCDE, 1'b1);
    word(21'h100001, 1'b0);
    word(21'h0F0F0F, 1'b0);
    word(21'h155555, 1'b1);
    SP = 1'b0;
    idle(2);
    SP = 1'b1;
    word(21'h1FFFFF, 1'b1);
    word(21'h000000, 1'b0);
    idle(6);

    // WIDTH=1: Z follows D
    word1(1'b1);
    word1(1'b0);
    word1(1'b1);
    word1(1'b1);
    idle(4);

`ifdef XOR_REDUCE_FRAME_EN
    // frame 0x1,0x3,0x1 with an idle slot inside: parity 0
    fword(21'h000001, 1'b1, 1'b0);
    idle(1);
    fword(21'h000003, 1'b0, 1'b0);
    exp0(1'b0, 1'b1, 1'b0);
    fword(21'h000001, 1'b0, 1'b1);
    idle(6);
    // single-word frame
    exp0(1'b1, 1'b1, 1'b0);
    fword(21'h000007, 1'b1, 1'b1);
    idle(6);
    // abort: old partial parity 1 must not leak into the new frame
    fword(21'h000000, 1'b1, 1'b0);
    fword(21'h000001, 1'b0, 1'b0);
    exp0(1'b0, 1'b0, 1'b1);
    fword(21'h000003, 1'b1, 1'b0);
    exp0(1'b0, 1'b1, 1'b0);
    fword(21'h000000, 1'b0, 1'b1);
    idle(6);
`endif

    // asynchronous clear with words in flight
    word(21'h000001, 1'b1);
    word(21'h000002, 1'b1);
    word(21'h000004, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CK);
      seen = ZV;
    end
    chk("clear_wait_first_result", seen, 1);
    #2;
    CD = 1'b1;
    #1;
    chk("clear_z", Z, 0);
    chk("clear_zv", ZV, 0);
    chk("clear_zf", ZF, 0);
    q0.delete();
    q1.delete();
    @(posedge CK);
    @(negedge CK);
    CD = 1'b0;
    @(posedge CK); #1;
    idle(6);
    word(21'h000007, 1'b1);
    idle(8);

    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
